xevious_inputs: RTL
===================

# xevious_inputs

Input conditioner for the Xevious core. It decodes PS/2 key events and merges them with the two MiSTer joysticks into registered, active-high player controls. It suppresses opposing-direction conflicts and shapes the coin signal into a fixed-length pulse. It sits between `hps_io` (`ps2_key`, `joystick_0/1`) and the `xevious` core's control inputs and DIP-switch bomb bits.

## Interface

Parameters:
- `COIN_PULSE`, default 1843200: coin output high time, in `clk_sys` cycles (100 ms at 18.432 MHz); must be ≥ 1.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
- `joystick_0`  in  16  player 1 pad: [0] R, [1] L, [2] D, [3] U, [4] fire, [5] bomb, [6] start1, [7] start2, [8] coin.
- `joystick_1`  in  16  player 2 pad, same bit layout.
- `up, down, left, right, fire, bomb`  out  1 each  player 1 controls.
- `up_2, down_2, left_2, right_2, fire_2, bomb_2`  out  1 each  player 2 controls.
- `start1, start2`  out  1 each  start buttons.
- `coin`  out  1  shaped coin pulse.

## Operation

Key event detection:
- A register `tog_q` holds the last `ps2_key[10]`, and an `armed` flag gates decoding.
- After reset, the first clock loads `tog_q` and sets `armed` without decoding, so a stale toggle level cannot produce a phantom event.
- An event is any cycle with `armed` high and `ps2_key[10] != tog_q`. On that cycle `tog_q` is updated.

Key map (event sets the key register to `ps2_key[9]`; unlisted codes are ignored):
- Extended bit is don't-care: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x14 bomb.
- Extended bit must be 0:
  - 0x29 fire.
  - 0x05 and 0x16 start1.
  - 0x06 and 0x1E start2.
  - 0x2E coin A, 0x36 coin B.
  - 0x2D up_2, 0x2B down_2, 0x23 left_2, 0x34 right_2, 0x1C fire_2, 0x1B bomb_2.

Merge:
- Player 1 raw control = key register OR the matching `joystick_0` bit.
- Player 2 raw control = key register OR the matching `joystick_1` bit.
- `start1` and `start2` = key register OR bit 6 / bit 7 of either joystick.
- Coin source = coin A OR coin B OR `joystick_0[8]` OR `joystick_1[8]`.

Direction conflicts, applied per player:
- If raw up and raw down are both 1, both outputs are 0.
- If raw left and raw right are both 1, both outputs are 0.
- One axis never affects the other.

Coin shaper:
- States: IDLE, PULSE, HOLD.
- IDLE: on a coin-source rising edge (source high, previous-cycle source low), load the counter with `COIN_PULSE-1` and go to PULSE.
- PULSE: `coin`=1. Decrement the counter each cycle. At 0, go to HOLD if the source is high, else IDLE.
- HOLD: `coin`=0. Return to IDLE when the source is low.
- No retrigger occurs while in PULSE or HOLD.
- The counter width is `$clog2(COIN_PULSE)` bits, minimum 1.

Reset:
- Every key register, `tog_q`, `armed`, the source edge register and all outputs are 0.
- The coin FSM is in IDLE.
- Reset is asynchronous: asserting it mid-pulse drops `coin` immediately.

## Timing

- All outputs are registered.
- Joystick change → output change: 1 cycle.
- Key event cycle N → key register updated at the edge ending N → output updated at the next edge (2-cycle latency).
- Coin: source rises in cycle N → `coin` high from edge N+1 for exactly `COIN_PULSE` cycles.
- Simultaneous key event and joystick change are merged by OR in the same output update.
- Two key events on consecutive cycles (toggle flips twice) are both decoded, in order.

## Test plan

- Reset held, `ps2_key[10]`=1 at release, no further toggle → no output ever asserts; a subsequent toggle with code 0x029, pressed=1 → `fire`=1 two cycles later.
- Key 0x175 pressed, then toggle with 0x175 released → `up` rises and falls, each change 2 cycles after its event; code 0x129 (extended) → `fire` unchanged.
- `joystick_0`=0x000C (up+down) → `up`=`down`=0. Add `ps2` right pressed → `right`=1 and `up`/`down` remain 0. Release down → `up`=1 after 1 cycle.
- `COIN_PULSE`=8, `joystick_1[8]` held high 20 cycles → `coin` high exactly 8 cycles, then low. Drop and raise the source → a second 8-cycle pulse.
- `COIN_PULSE`=8, source is a 1-cycle pulse → `coin` still high exactly 8 cycles. A second rising edge during PULSE → no extension.
- `reset_n` asserted at cycle 3 of a coin pulse → `coin` low asynchronously. After release, the source still high produces no pulse until it goes low and then rises again.

Source files
------------

// File: rtl/xevious_inputs_if.sv
// Input/control bundle between hps_io and the Xevious core.
// The master side drives the PS/2 key and joysticks; the slave side returns player controls.
interface xevious_inputs_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        up, down, left, right, fire, bomb;
  logic        up_2, down_2, left_2, right_2, fire_2, bomb_2;
  logic        start1, start2;
  logic        coin;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  up, down, left, right, fire, bomb,
    input  up_2, down_2, left_2, right_2, fire_2, bomb_2,
    input  start1, start2, coin
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output up, down, left, right, fire, bomb,
    output up_2, down_2, left_2, right_2, fire_2, bomb_2,
    output start1, start2, coin
  );
endinterface

// File: rtl/xevious_inputs.sv
// Xevious input conditioner: PS/2 key decode merged with both joysticks.
// It also resolves opposing-direction conflicts and stretches the coin input into a fixed-length pulse.
module xevious_inputs #(
  parameter int unsigned COIN_PULSE = 1843200
) (
  input  logic clk_sys,
  input  logic reset_n,
  xevious_inputs_if.slave io
);

  localparam int unsigned CNT_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_PULSE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} coin_state_t;

  logic       tog_q, armed;
  logic       key_ev_c;
  logic       pressed_c, ext_c;
  logic [7:0] code_c;

  logic k_up, k_down, k_left, k_right, k_fire, k_bomb;
  logic k_up2, k_down2, k_left2, k_right2, k_fire2, k_bomb2;
  logic k_start1, k_start2, k_coin_a, k_coin_b;

  logic raw_up_c, raw_down_c, raw_left_c, raw_right_c, raw_fire_c, raw_bomb_c;
  logic raw_up2_c, raw_down2_c, raw_left2_c, raw_right2_c, raw_fire2_c, raw_bomb2_c;
  logic raw_start1_c, raw_start2_c, coin_src_c;

  logic up_q, down_q, left_q, right_q, fire_q, bomb_q;
  logic up2_q, down2_q, left2_q, right2_q, fire2_q, bomb2_q;
  logic start1_q, start2_q, coin_q;

  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q;
  logic             unused_c;

  assign pressed_c = io.ps2_key[9];
  assign ext_c     = io.ps2_key[8];
  assign code_c    = io.ps2_key[7:0];
  assign key_ev_c  = armed && (io.ps2_key[10] != tog_q);
  assign unused_c  = &{1'b0, io.joystick_0[15:9], io.joystick_1[15:9]};

  // Key event detection and key map; the first post-reset clock only samples the toggle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      armed    <= 1'b0;
      k_up     <= 1'b0; k_down   <= 1'b0; k_left   <= 1'b0; k_right  <= 1'b0;
      k_fire   <= 1'b0; k_bomb   <= 1'b0;
      k_up2    <= 1'b0; k_down2  <= 1'b0; k_left2  <= 1'b0; k_right2 <= 1'b0;
      k_fire2  <= 1'b0; k_bomb2  <= 1'b0;
      k_start1 <= 1'b0; k_start2 <= 1'b0; k_coin_a <= 1'b0; k_coin_b <= 1'b0;
    end else if (!armed) begin
      tog_q <= io.ps2_key[10];
      armed <= 1'b1;
    end else if (key_ev_c) begin
      tog_q <= io.ps2_key[10];
      case (code_c)
        8'h75: k_up    <= pressed_c;
        8'h72: k_down  <= pressed_c;
        8'h6B: k_left  <= pressed_c;
        8'h74: k_right <= pressed_c;
        8'h14: k_bomb  <= pressed_c;
        8'h29: if (!ext_c) k_fire   <= pressed_c;
        8'h05: if (!ext_c) k_start1 <= pressed_c;
        8'h16: if (!ext_c) k_start1 <= pressed_c;
        8'h06: if (!ext_c) k_start2 <= pressed_c;
        8'h1E: if (!ext_c) k_start2 <= pressed_c;
        8'h2E: if (!ext_c) k_coin_a <= pressed_c;
        8'h36: if (!ext_c) k_coin_b <= pressed_c;
        8'h2D: if (!ext_c) k_up2    <= pressed_c;
        8'h2B: if (!ext_c) k_down2  <= pressed_c;
        8'h23: if (!ext_c) k_left2  <= pressed_c;
        8'h34: if (!ext_c) k_right2 <= pressed_c;
        8'h1C: if (!ext_c) k_fire2  <= pressed_c;
        8'h1B: if (!ext_c) k_bomb2  <= pressed_c;
        default: ;
      endcase
    end
  end

  // Keyboard and joystick merge
  always_comb begin
    raw_up_c     = k_up     | io.joystick_0[3];
    raw_down_c   = k_down   | io.joystick_0[2];
    raw_left_c   = k_left   | io.joystick_0[1];
    raw_right_c  = k_right  | io.joystick_0[0];
    raw_fire_c   = k_fire   | io.joystick_0[4];
    raw_bomb_c   = k_bomb   | io.joystick_0[5];
    raw_up2_c    = k_up2    | io.joystick_1[3];
    raw_down2_c  = k_down2  | io.joystick_1[2];
    raw_left2_c  = k_left2  | io.joystick_1[1];
    raw_right2_c = k_right2 | io.joystick_1[0];
    raw_fire2_c  = k_fire2  | io.joystick_1[4];
    raw_bomb2_c  = k_bomb2  | io.joystick_1[5];
    raw_start1_c = k_start1 | io.joystick_0[6] | io.joystick_1[6];
    raw_start2_c = k_start2 | io.joystick_0[7] | io.joystick_1[7];
    coin_src_c   = k_coin_a | k_coin_b | io.joystick_0[8] | io.joystick_1[8];
  end

  // Registered controls; opposing directions on one axis cancel each other
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      up_q  <= 1'b0; down_q  <= 1'b0; left_q  <= 1'b0; right_q  <= 1'b0;
      fire_q <= 1'b0; bomb_q <= 1'b0;
      up2_q <= 1'b0; down2_q <= 1'b0; left2_q <= 1'b0; right2_q <= 1'b0;
      fire2_q <= 1'b0; bomb2_q <= 1'b0;
      start1_q <= 1'b0; start2_q <= 1'b0;
    end else begin
      up_q     <= raw_up_c    & ~raw_down_c;
      down_q   <= raw_down_c  & ~raw_up_c;
      left_q   <= raw_left_c  & ~raw_right_c;
      right_q  <= raw_right_c & ~raw_left_c;
      fire_q   <= raw_fire_c;
      bomb_q   <= raw_bomb_c;
      up2_q    <= raw_up2_c    & ~raw_down2_c;
      down2_q  <= raw_down2_c  & ~raw_up2_c;
      left2_q  <= raw_left2_c  & ~raw_right2_c;
      right2_q <= raw_right2_c & ~raw_left2_c;
      fire2_q  <= raw_fire2_c;
      bomb2_q  <= raw_bomb2_c;
      start1_q <= raw_start1_c;
      start2_q <= raw_start2_c;
    end
  end

  // Coin shaper state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= coin_src_c;
      coin_q  <= (state_d == ST_PULSE);
    end
  end

  // Edge detect waits for armed so a source already high at reset release is not a new coin
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (armed && coin_src_c && !src_q) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = coin_src_c ? ST_HOLD : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!coin_src_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.up      = up_q;
  assign io.down    = down_q;
  assign io.left    = left_q;
  assign io.right   = right_q;
  assign io.fire    = fire_q;
  assign io.bomb    = bomb_q;
  assign io.up_2    = up2_q;
  assign io.down_2  = down2_q;
  assign io.left_2  = left2_q;
  assign io.right_2 = right2_q;
  assign io.fire_2  = fire2_q;
  assign io.bomb_2  = bomb2_q;
  assign io.start1  = start1_q;
  assign io.start2  = start2_q;
  assign io.coin    = coin_q;

endmodule
